// File: rtl/pmem_multi_arbiter.sv
// pmem_multi_arbiter: NUM_RD round-robin read channels plus one write channel
// sharing a single physical-memory port.
// Optional performance counters are compiled in with `define PMEM_ARB_PERF_EN.
//
// Handshake: every requester raises its req level and holds req and address
// (and write data) stable until its one-cycle resp pulse. The memory side sees
// a read/write strobe held until a one-cycle pmem_resp.
module pmem_multi_arbiter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int LINE_WIDTH    = 256,
  parameter int NUM_RD        = 2,
  parameter int WR_STARVE_MAX = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_RD-1:0]            rd_req,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [LINE_WIDTH-1:0]        rd_rdata,
  output logic [NUM_RD-1:0]            rd_resp,
  input  logic                         wr_req,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [LINE_WIDTH-1:0]        wr_wdata,
  output logic                         wr_resp,
  output logic                         pmem_read,
  output logic                         pmem_write,
  output logic [ADDR_WIDTH-1:0]        pmem_address,
  output logic [LINE_WIDTH-1:0]        pmem_wdata,
  input  logic [LINE_WIDTH-1:0]        pmem_rdata,
  input  logic                         pmem_resp,
  output logic                         busy
`ifdef PMEM_ARB_PERF_EN
  ,
  input  logic                         perf_clr,
  output logic [31:0]                  perf_rd_cnt,
  output logic [31:0]                  perf_wr_cnt,
  output logic [31:0]                  perf_stall_cnt
`endif
);

  localparam int IDXW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
  localparam int SW   = $clog2(WR_STARVE_MAX + 1);
  localparam int OFFS = $clog2(LINE_WIDTH / 8);
  localparam int LAW  = ADDR_WIDTH - OFFS;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_CAPTURE = 3'd1,
    READING    = 3'd2,
    WR_CAPTURE = 3'd3,
    WRITING    = 3'd4,
    FINISH     = 3'd5
  } state_e;

  state_e                  state_q;
  logic [IDXW-1:0]         grant_q;
  logic [IDXW-1:0]         rr_ptr_q;
  logic [SW-1:0]           streak_q;
  logic                    is_wr_q;
  logic                    busy_q;
  logic                    pmem_read_q;
  logic                    pmem_write_q;
  logic [ADDR_WIDTH-1:0]   pmem_address_q;
  logic [LINE_WIDTH-1:0]   pmem_wdata_q;
  logic [LINE_WIDTH-1:0]   rd_rdata_q;
  logic [NUM_RD-1:0]       rd_resp_q;
  logic                    wr_resp_q;

  logic                    rd_any;
  logic                    rd_found;
  logic [IDXW-1:0]         rd_cand;
  logic                    raw_hit;
  logic                    streak_full;
  logic                    wr_wins;
  logic [ADDR_WIDTH-1:0]   grant_addr;
  logic [NUM_RD-1:0]       grant_onehot;

  // Arbitration: rotating read search, RAW line compare, starvation guard.
  always_comb begin
    rd_any      = |rd_req;
    rd_found    = 1'b0;
    rd_cand     = '0;
    raw_hit     = 1'b0;
    streak_full = (streak_q >= SW'(WR_STARVE_MAX));
    for (int k = 1; k <= NUM_RD; k++) begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (!rd_found && rd_req[i] && (((int'(rr_ptr_q) + k) % NUM_RD) == i)) begin
          rd_found = 1'b1;
          rd_cand  = IDXW'(i);
        end
      end
    end
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_req[i] &&
          (rd_addr[i*ADDR_WIDTH+OFFS +: LAW] == wr_addr[ADDR_WIDTH-1:OFFS])) begin
        raw_hit = 1'b1;
      end
    end
    wr_wins = wr_req && (!rd_any || streak_full || raw_hit);
  end

  // Granted channel's address and one-hot completion vector.
  always_comb begin
    grant_addr   = '0;
    grant_onehot = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (grant_q == IDXW'(i)) begin
        grant_addr      = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        grant_onehot[i] = 1'b1;
      end
    end
  end

  // Main FSM with registered strobes, responses and data paths.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      rr_ptr_q       <= IDXW'(NUM_RD - 1);
      streak_q       <= '0;
      is_wr_q        <= 1'b0;
      busy_q         <= 1'b0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
      rd_rdata_q     <= '0;
      rd_resp_q      <= '0;
      wr_resp_q      <= 1'b0;
    end else begin
      rd_resp_q <= '0;
      wr_resp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_wins) begin
            state_q <= WR_CAPTURE;
            is_wr_q <= 1'b1;
            busy_q  <= 1'b1;
          end else if (rd_found) begin
            state_q <= RD_CAPTURE;
            grant_q <= rd_cand;
            is_wr_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        RD_CAPTURE: begin
          pmem_address_q <= grant_addr;
          rr_ptr_q       <= grant_q;
          pmem_read_q    <= 1'b1;
          state_q        <= READING;
        end
        WR_CAPTURE: begin
          pmem_address_q <= wr_addr;
          pmem_wdata_q   <= wr_wdata;
          pmem_write_q   <= 1'b1;
          state_q        <= WRITING;
        end
        READING: begin
          if (pmem_resp) begin
            rd_rdata_q  <= pmem_rdata;
            pmem_read_q <= 1'b0;
            rd_resp_q   <= grant_onehot;
            state_q     <= FINISH;
          end
        end
        WRITING: begin
          if (pmem_resp) begin
            pmem_write_q <= 1'b0;
            wr_resp_q    <= 1'b1;
            state_q      <= FINISH;
          end
        end
        FINISH: begin
          if (is_wr_q || !wr_req) begin
            streak_q <= '0;
          end else if (!streak_full) begin
            streak_q <= streak_q + 1'b1;
          end
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          pmem_read_q  <= 1'b0;
          pmem_write_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign rd_rdata     = rd_rdata_q;
  assign rd_resp      = rd_resp_q;
  assign wr_resp      = wr_resp_q;
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;
  assign busy         = busy_q;

`ifdef PMEM_ARB_PERF_EN
  logic [31:0] perf_rd_q;
  logic [31:0] perf_wr_q;
  logic [31:0] perf_stall_q;

  // Completion and stall counters; clear wins over increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_rd_q    <= '0;
      perf_wr_q    <= '0;
      perf_stall_q <= '0;
    end else if (perf_clr) begin
      perf_rd_q    <= '0;
      perf_wr_q    <= '0;
      perf_stall_q <= '0;
    end else begin
      if (state_q == FINISH && !is_wr_q) perf_rd_q <= perf_rd_q + 32'd1;
      if (state_q == FINISH && is_wr_q)  perf_wr_q <= perf_wr_q + 32'd1;
      if (busy_q && (rd_any || wr_req))  perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_rd_cnt    = perf_rd_q;
  assign perf_wr_cnt    = perf_wr_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_pmem_multi_arbiter.sv
// Directed bench for pmem_multi_arbiter with a response scoreboard.
module tb_pmem_multi_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
  localparam int NR = 2;
  localparam int EW = 1 + 3 + AW + LW;

  logic              clk;
  logic              reset_n;
  logic [NR-1:0]     rd_req;
  logic [NR*AW-1:0]  rd_addr;
  logic [LW-1:0]     rd_rdata;
  logic [NR-1:0]     rd_resp;
  logic              wr_req;
  logic [AW-1:0]     wr_addr;
  logic [LW-1:0]     wr_wdata;
  logic              wr_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [AW-1:0]     pmem_address;
  logic [LW-1:0]     pmem_wdata;
  logic [LW-1:0]     pmem_rdata;
  logic              pmem_resp;
  logic              busy;
`ifdef PMEM_ARB_PERF_EN
  logic              perf_clr;
  logic [31:0]       perf_rd_cnt;
  logic [31:0]       perf_wr_cnt;
  logic [31:0]       perf_stall_cnt;
`endif

  pmem_multi_arbiter #(
    .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .NUM_RD(NR), .WR_STARVE_MAX(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdata(rd_rdata), .rd_resp(rd_resp),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_wdata(wr_wdata), .wr_resp(wr_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .busy(busy)
`ifdef PMEM_ARB_PERF_EN
    , .perf_clr(perf_clr), .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- bookkeeping ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  function automatic logic [LW-1:0] rdata_of(input logic [AW-1:0] a);
    return {4{a, ~a}};
  endfunction

  function automatic logic [LW-1:0] wdata_of(input logic [AW-1:0] a);
    return {8{a + 32'h1111_1111}};
  endfunction

  task automatic push_exp(input logic is_wr, input int ch, input logic [AW-1:0] a,
                          input logic [LW-1:0] d);
    logic [2:0] c;
    c = 3'(ch);
    exp_q.push_back({is_wr, c, a, d});
  endtask

  // ---------------- memory model ----------------
  int            mem_delay = 1;
  int            mem_cnt   = 0;
  logic          a5_mode   = 1'b0;
  logic          stray_resp = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic [LW-1:0] last_wdata = '0;
  int            rd_strobe_cyc = 0;

  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (pmem_read) rd_strobe_cyc++;
      if (!reset_n) begin
        mem_cnt   = 0;
        pmem_resp = 1'b0;
      end else if ((pmem_read || pmem_write) && !pmem_resp) begin
        mem_cnt++;
        if (mem_cnt >= mem_delay) begin
          pmem_resp  = 1'b1;
          pmem_rdata = a5_mode ? {32{8'hA5}} : rdata_of(pmem_address);
          last_addr  = pmem_address;
          last_wdata = pmem_wdata;
          mem_cnt    = 0;
        end
      end else begin
        pmem_resp = stray_resp;
      end
    end
  end

  // ---------------- requester driver ----------------
  int rd_left[NR];
  int wr_left = 0;

  task automatic start_read(input int ch, input logic [AW-1:0] a, input int n);
    rd_addr[ch*AW +: AW] = a;
    rd_left[ch] = n;
    rd_req[ch]  = 1'b1;
  endtask

  task automatic start_write(input logic [AW-1:0] a, input int n);
    wr_addr  = a;
    wr_wdata = wdata_of(a);
    wr_left  = n;
    wr_req   = 1'b1;
  endtask

  // Drops each request level once its transaction count is used up.
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      for (int i = 0; i < NR; i++) begin
        if (rd_resp[i] && rd_left[i] > 0) begin
          rd_left[i]--;
          if (rd_left[i] == 0) rd_req[i] = 1'b0;
        end
      end
      if (wr_resp && wr_left > 0) begin
        wr_left--;
        if (wr_left == 0) wr_req = 1'b0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  int last_resp_cyc = 0;

  initial forever begin
    logic [EW-1:0] e;
    logic [NR:0]   exp_kind;
    @(negedge clk);
    if (reset_n && (rd_resp != '0 || wr_resp)) begin
      last_resp_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_resp", {wr_resp, rd_resp}, '0);
      end else begin
        e = exp_q.pop_front();
        exp_kind = '0;
        if (e[EW-1]) exp_kind[NR] = 1'b1;
        else exp_kind[int'(e[EW-2 -: 3])] = 1'b1;
        check("resp_kind", {wr_resp, rd_resp}, exp_kind);
        check("resp_addr", last_addr, e[LW +: AW]);
        if (e[EW-1]) check("wr_data", last_wdata, e[LW-1:0]);
        else         check("rd_data", rd_rdata, e[LW-1:0]);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic clear_reqs();
    rd_req  = '0;
    rd_addr = '0;
    wr_req  = 1'b0;
    wr_addr = '0;
    wr_wdata = '0;
    for (int i = 0; i < NR; i++) rd_left[i] = 0;
    wr_left = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    clear_reqs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_done(input string name, input int budget);
    logic done;
    done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      done = (rd_left[0] == 0) && (rd_left[1] == 0) && (wr_left == 0) &&
             (exp_q.size() == 0) && !busy;
      if (done) break;
    end
    check(name, done, 1'b1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int t0;
    logic seen;
    reset_n = 1'b0;
    clear_reqs();
`ifdef PMEM_ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_pmem_read", pmem_read, 1'b0);
    check("rst_pmem_write", pmem_write, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rd_resp", rd_resp, '0);
    check("rst_wr_resp", wr_resp, 1'b0);
    check("rst_pmem_address", pmem_address, '0);
    check("rst_pmem_wdata", pmem_wdata, '0);
    check("rst_rd_rdata", rd_rdata, '0);
    reset_n = 1'b1;
    @(negedge clk);

    // Stray memory response while idle is ignored.
    stray_resp = 1'b1;
    @(negedge clk);
    stray_resp = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_busy", busy, 1'b0);
    check("stray_pmem_read", pmem_read, 1'b0);

    // Single read with a 3-cycle memory.
    mem_delay = 3;
    a5_mode   = 1'b1;
    rd_strobe_cyc = 0;
    push_exp(1'b0, 0, 32'h0000_1000, {32{8'hA5}});
    t0 = cyc;
    start_read(0, 32'h0000_1000, 1);
    wait_done("done_single", 40);
    check("single_latency", 32'(last_resp_cyc - t0), 32'd5);
    check("single_strobe_cycles", 32'(rd_strobe_cyc), 32'd3);
    a5_mode   = 1'b0;
    mem_delay = 1;

    // Round robin after reset: 0,1,0,1.
    do_reset();
    push_exp(1'b0, 0, 32'h0000_3000, rdata_of(32'h0000_3000));
    push_exp(1'b0, 1, 32'h0000_4040, rdata_of(32'h0000_4040));
    push_exp(1'b0, 0, 32'h0000_3000, rdata_of(32'h0000_3000));
    push_exp(1'b0, 1, 32'h0000_4040, rdata_of(32'h0000_4040));
    start_read(0, 32'h0000_3000, 2);
    start_read(1, 32'h0000_4040, 2);
    wait_done("done_rr", 100);

    // Write starvation guard: four reads, then the write, then reads resume.
    do_reset();
    push_exp(1'b0, 0, 32'h0000_3000, rdata_of(32'h0000_3000));
    push_exp(1'b0, 1, 32'h0000_4040, rdata_of(32'h0000_4040));
    push_exp(1'b0, 0, 32'h0000_3000, rdata_of(32'h0000_3000));
    push_exp(1'b0, 1, 32'h0000_4040, rdata_of(32'h0000_4040));
    push_exp(1'b1, 0, 32'h0000_5000, wdata_of(32'h0000_5000));
    push_exp(1'b0, 0, 32'h0000_3000, rdata_of(32'h0000_3000));
    push_exp(1'b0, 1, 32'h0000_4040, rdata_of(32'h0000_4040));
    start_read(0, 32'h0000_3000, 3);
    start_read(1, 32'h0000_4040, 3);
    start_write(32'h0000_5000, 1);
    wait_done("done_starve", 200);

    // RAW: same 32-byte line, write goes first.
    push_exp(1'b1, 0, 32'h0000_2000, wdata_of(32'h0000_2000));
    push_exp(1'b0, 1, 32'h0000_2004, rdata_of(32'h0000_2004));
    start_read(1, 32'h0000_2004, 1);
    start_write(32'h0000_2000, 1);
    wait_done("done_raw", 60);

    // Neighbouring line is not a hazard: read goes first.
    push_exp(1'b0, 0, 32'h0000_2020, rdata_of(32'h0000_2020));
    push_exp(1'b1, 0, 32'h0000_2000, wdata_of(32'h0000_2000));
    start_read(0, 32'h0000_2020, 1);
    start_write(32'h0000_2000, 1);
    wait_done("done_noraw", 60);
    check("hold_rd_rdata", rd_rdata, rdata_of(32'h0000_2020));
    check("hold_pmem_address", pmem_address, 32'h0000_2000);
    check("hold_pmem_wdata", pmem_wdata, wdata_of(32'h0000_2000));

    // Reset while reading channel 1; afterwards channel 0 goes first.
    mem_delay = 20;
    start_read(0, 32'h0000_6000, 1);
    start_read(1, 32'h0000_7000, 1);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (pmem_read) begin
        seen = 1'b1;
        break;
      end
    end
    check("midrst_reading", seen, 1'b1);
    check("midrst_addr", pmem_address, 32'h0000_7000);
    reset_n = 1'b0;
    #1;
    check("midrst_pmem_read", pmem_read, 1'b0);
    check("midrst_busy", busy, 1'b0);
    mem_delay = 1;
    push_exp(1'b0, 0, 32'h0000_6000, rdata_of(32'h0000_6000));
    push_exp(1'b0, 1, 32'h0000_7000, rdata_of(32'h0000_7000));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_done("done_midrst", 60);

`ifdef PMEM_ARB_PERF_EN
    // Counters: three reads and one write, then a clear.
    do_reset();
    push_exp(1'b0, 0, 32'h0000_3000, rdata_of(32'h0000_3000));
    push_exp(1'b0, 1, 32'h0000_4040, rdata_of(32'h0000_4040));
    push_exp(1'b0, 0, 32'h0000_3000, rdata_of(32'h0000_3000));
    push_exp(1'b1, 0, 32'h0000_5000, wdata_of(32'h0000_5000));
    start_read(0, 32'h0000_3000, 2);
    start_read(1, 32'h0000_4040, 1);
    start_write(32'h0000_5000, 1);
    wait_done("done_perf", 100);
    check("perf_rd_cnt", perf_rd_cnt, 32'd3);
    check("perf_wr_cnt", perf_wr_cnt, 32'd1);
    perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0;
    check("perf_rd_clr", perf_rd_cnt, 32'd0);
    check("perf_wr_clr", perf_wr_cnt, 32'd0);
    check("perf_stall_clr", perf_stall_cnt, 32'd0);
`endif

    repeat (3) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
